// File: rtl/gpio_atr_io_ext.sv
// gpio_atr_io_ext: one GPIO bank between the radio core's GPIO/ATR settings
// registers and the device inout pins. It provides:
//   - four-state ATR output selection with per-pin manual override
//   - a registered output path and a registered direction path
//   - a SYNC_STAGES input synchroniser with per-pin debounce
//   - sticky rise/fall interrupt flags and a registered interrupt line
// Build option: define GPIO_ATR_IO_OPEN_DRAIN_EN to let gpio_od select
// open-drain drive per pin. Without it, every pin is push-pull and gpio_od
// is ignored.
module gpio_atr_io_ext #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,   // legal range 2..4
    parameter int DEBOUNCE_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            atr_state,
    input  logic [WIDTH-1:0]      atr_idle,
    input  logic [WIDTH-1:0]      atr_rx,
    input  logic [WIDTH-1:0]      atr_tx,
    input  logic [WIDTH-1:0]      atr_fdx,
    input  logic [WIDTH-1:0]      atr_disable,
    input  logic [WIDTH-1:0]      gpio_out,
    input  logic [WIDTH-1:0]      gpio_ddr,
    input  logic [WIDTH-1:0]      gpio_od,
    input  logic [DEBOUNCE_W-1:0] debounce_cnt,
    input  logic [WIDTH-1:0]      irq_rise_en,
    input  logic [WIDTH-1:0]      irq_fall_en,
    input  logic [WIDTH-1:0]      irq_clear,
    output logic [WIDTH-1:0]      gpio_in,
    output logic [WIDTH-1:0]      irq_status,
    output logic                  irq,
    inout  wire  [WIDTH-1:0]      gpio_pins
);

    // The settle counter covers the synchroniser flush that follows reset.
    localparam logic [2:0] SETTLE_LAST = 3'(SYNC_STAGES);

    logic [WIDTH-1:0] atr_val;
    logic [WIDTH-1:0] sel;
    (* IOB = "TRUE" *) logic [WIDTH-1:0] out_q;
    (* IOB = "TRUE" *) logic [WIDTH-1:0] ddr_q;
    logic [WIDTH-1:0] drv_en;

    (* IOB = "TRUE" *) logic [WIDTH-1:0] sync_s0;
    logic [WIDTH-1:0] sync_tail [SYNC_STAGES-1];
    logic [WIDTH-1:0] raw;

    logic [DEBOUNCE_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] mismatch;
    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] armed;
    logic [2:0]       settle_cnt;
    logic             settled;
    logic [WIDTH-1:0] edge_set;

    // ATR value for the current radio state, then the per-pin manual override
    always_comb begin
        atr_val = atr_idle;
        case (atr_state)
            2'b00:   atr_val = atr_idle;
            2'b01:   atr_val = atr_rx;
            2'b10:   atr_val = atr_tx;
            default: atr_val = atr_fdx;
        endcase
        sel = (atr_disable & gpio_out) | (~atr_disable & atr_val);
    end

    // Output and direction registers; reset releases every pin
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q <= '0;
            ddr_q <= '0;
        end else begin
            out_q <= sel;
            ddr_q <= gpio_ddr;
        end
    end

`ifdef GPIO_ATR_IO_OPEN_DRAIN_EN
    logic [WIDTH-1:0] od_q;

    // The open-drain select is registered alongside ddr so that all pin
    // controls share the same one-cycle latency
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            od_q <= '0;
        end else begin
            od_q <= gpio_od;
        end
    end

    // An open-drain pin only ever drives low; a high output releases the pin
    assign drv_en = ddr_q & ~(od_q & out_q);
`else
    wire unused_od = ^gpio_od;
    assign drv_en = ddr_q;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign gpio_pins[i] = drv_en[i] ? out_q[i] : 1'bz;
    end

    // Input synchroniser; the first stage sits in the IOB
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_s0 <= '0;
            for (int s = 0; s < SYNC_STAGES - 1; s++) begin
                sync_tail[s] <= '0;
            end
        end else begin
            sync_s0      <= gpio_pins;
            sync_tail[0] <= sync_s0;
            for (int s = 1; s < SYNC_STAGES - 1; s++) begin
                sync_tail[s] <= sync_tail[s-1];
            end
        end
    end

    assign raw      = sync_tail[SYNC_STAGES-2];
    assign mismatch = raw ^ stable;
    assign settled  = (settle_cnt == SETTLE_LAST);

    // A pin updates once its mismatch has persisted past the threshold
    always_comb begin
        upd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            upd[i] = mismatch[i] && (cnt[i] >= debounce_cnt);
        end
    end

    // Per-pin debounce counters and the filtered pin state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!mismatch[i]) begin
                    cnt[i] <= '0;
                end else if (upd[i]) begin
                    stable[i] <= raw[i];
                    cnt[i]    <= '0;
                end else if (cnt[i] != '1) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Edge detection is armed per pin only once stable reflects the real pin:
    // after the synchroniser has flushed, either raw already matches stable or
    // the first update loads it. That first load never raises a flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            settle_cnt <= '0;
            armed      <= '0;
        end else begin
            if (!settled) begin
                settle_cnt <= settle_cnt + 3'd1;
            end else begin
                armed <= armed | ~mismatch | upd;
            end
        end
    end

    assign edge_set = upd & armed & ((raw & irq_rise_en) | (~raw & irq_fall_en));

    // Sticky status: a new edge wins over a clear in the same cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            irq_status <= (irq_status & ~irq_clear) | edge_set;
            irq        <= |irq_status;
        end
    end

    assign gpio_in = stable;

endmodule
